// File: rtl/lcd_16207_responder.sv
// lcd_16207_responder: HD44780-style panel model on the 16207 LCD pins (DDRAM, AC, busy flag, read-back)
module lcd_16207_responder #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 160,
    parameter int HOME_CYCLES  = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_data_in,
    output logic [7:0] LCD_data_out,
    output logic       LCD_data_oe,
    output logic       busy,
    output logic [6:0] addr_counter,
    output logic       display_on,
    output logic       violation,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;
    state_t      r_state, w_state_nx;
    logic [15:0] r_cnt, w_cnt_nx;
    logic [7:0]  r_clr, w_clr_nx;
    logic        r_e_q, r_rs, r_rw, r_id, r_n, r_disp;
    logic [7:0]  r_dat, r_dbg;
    logic [6:0]  r_ac;
    logic [7:0]  r_ram [128];
    logic        w_idle, w_commit, w_act, w_iwr, w_dacc, w_clearing, w_we;
    logic [6:0]  w_waddr, w_step;
    logic [7:0]  w_wdata;

    assign w_idle     = r_state == IDLE;
    assign w_commit   = r_e_q & ~LCD_E & ~reset;
    assign w_act      = w_commit & w_idle;
    assign w_iwr      = w_act & ~r_rs & ~r_rw;
    assign w_dacc     = w_act & r_rs;
    assign w_clearing = (r_state == CLEAR) & ~r_clr[7];
    assign w_we       = ~reset & (w_clearing | (w_dacc & ~r_rw));
    assign w_waddr    = w_clearing ? r_clr[6:0] : r_ac;
    assign w_wdata    = w_clearing ? 8'h20 : r_dat;
    // two-line mode jumps the gaps between 0x27/0x40 and 0x67/0x00; one-line wraps at 0x4F
    assign w_step = r_id ? (r_n ? (r_ac == 7'h27 ? 7'h40 : r_ac == 7'h67 ? 7'h00 : r_ac + 7'd1)
                                : (r_ac == 7'h4F ? 7'h00 : r_ac + 7'd1))
                         : (r_n ? (r_ac == 7'h40 ? 7'h27 : r_ac == 7'h00 ? 7'h67 : r_ac - 7'd1)
                                : (r_ac == 7'h00 ? 7'h4F : r_ac - 7'd1));

    assign busy         = reset | ~w_idle;
    assign addr_counter = r_ac;
    assign display_on   = r_disp;
    assign dbg_data     = r_dbg;
    assign violation    = w_commit & ~w_idle & (r_rs | ~r_rw);
    assign LCD_data_oe  = ~reset & LCD_E & LCD_RW;
    assign LCD_data_out = ~LCD_data_oe ? 8'h00 : LCD_RS ? r_ram[r_ac] : {busy, r_ac};

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_clr_nx   = r_clr;
        if (!w_idle) begin
            w_state_nx = (r_cnt == 16'd0) ? IDLE : r_state;
            w_cnt_nx   = (r_cnt == 16'd0) ? 16'd0 : r_cnt - 16'd1;
            w_clr_nx   = r_clr + {7'd0, w_clearing};
        end else if (w_iwr && r_dat == 8'h01) begin
            w_state_nx = CLEAR;
            w_cnt_nx   = 16'(CLEAR_CYCLES - 1);
            w_clr_nx   = 8'd0;
        end else if (w_iwr && r_dat[7:1] == 7'h01) begin
            w_state_nx = EXEC;
            w_cnt_nx   = 16'(HOME_CYCLES - 1);
        end else if (w_dacc || (w_iwr && r_dat != 8'h00)) begin
            w_state_nx = EXEC;
            w_cnt_nx   = 16'(BUSY_CYCLES - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_cnt   <= 16'(CLEAR_CYCLES - 1);
            r_clr   <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_clr   <= w_clr_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_q  <= 1'b0;
            r_rs   <= 1'b0;
            r_rw   <= 1'b0;
            r_dat  <= 8'h00;
            r_ac   <= 7'h00;
            r_id   <= 1'b1;
            r_n    <= 1'b0;
            r_disp <= 1'b0;
            r_dbg  <= 8'h00;
        end else begin
            r_e_q <= LCD_E;
            if (LCD_E) {r_rs, r_rw, r_dat} <= {LCD_RS, LCD_RW, LCD_data_in};
            r_dbg <= (w_we && w_waddr == dbg_addr) ? w_wdata : r_ram[dbg_addr];
            if (w_dacc) r_ac <= w_step;
            else if (w_iwr) begin
                if (r_dat[7]) r_ac <= r_dat[6:0];
                else if (r_dat[7:5] == 3'b001) r_n <= r_dat[3];
                else if (r_dat[7:3] == 5'b00001) r_disp <= r_dat[2];
                else if (r_dat[7:2] == 6'b000001) r_id <= r_dat[1];
                else if (r_dat[7:1] == 7'b0000001) r_ac <= 7'h00;
                else if (r_dat == 8'h01) begin
                    r_ac <= 7'h00;
                    r_id <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_ram[w_waddr] <= w_wdata;
    end
endmodule

// File: tb/tb_lcd_16207_responder.sv
// tb_lcd_16207_responder: randomized pin-level stimulus, behavioural panel model, queue-based monitor
module tb_lcd_16207_responder;
    localparam int BUSY = 40, CLR = 160, HOME = 80;
    logic       clk = 1'b0, reset = 1'b1, LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
    logic [7:0] LCD_data_in = 8'h00;
    logic [6:0] dbg_addr = 7'h00;
    logic [7:0] LCD_data_out, dbg_data;
    logic       LCD_data_oe, busy, display_on, violation;
    logic [6:0] addr_counter;

    lcd_16207_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLR), .HOME_CYCLES(HOME)) dut (
        .clk(clk), .reset(reset), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_data_in(LCD_data_in), .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe),
        .busy(busy), .addr_counter(addr_counter), .display_on(display_on), .violation(violation),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    logic [7:0] mem [128];
    logic [6:0] ac;
    logic       id, nl, disp;
    int         busy_until;
    int         busy_q[$], viol_q[$], dbg_cyc_q[$];
    logic [7:0] bus_q[$], dbg_q[$];
    int         run = 0;
    logic       prev_oe = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // AC walks a ring of 80 display positions; addresses off the ring just move by one
    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc, input logic two);
        int pos;
        if (two ? !(a < 7'h28 || (a >= 7'h40 && a < 7'h68)) : a >= 7'h50)
            return inc ? a + 7'd1 : a - 7'd1;
        pos = (two && a >= 7'h40) ? int'(a) - 'h40 + 40 : int'(a);
        pos = (pos + (inc ? 1 : 79)) % 80;
        return (two && pos >= 40) ? 7'(pos - 40 + 'h40) : 7'(pos);
    endfunction

    task automatic start_busy(input int c, input int len);
        busy_until = c + len;
        busy_q.push_back(len);
    endtask

    task automatic model_reset(input int p);
        ac = 7'h00; id = 1'b1; nl = 1'b0; disp = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h20;
        busy_until = p + CLR - 1;
        busy_q.push_back(CLR);
    endtask

    task automatic model_commit(input logic rs, input logic rw, input logic [7:0] d, input int c);
        if (!rs && rw) return;
        if (c <= busy_until) begin
            viol_q.push_back(c);
            return;
        end
        if (rs) begin
            if (!rw) mem[ac] = d;
            ac = step_ac(ac, id, nl);
            start_busy(c, BUSY);
            return;
        end
        if (d == 8'h00) return;
        if (d[7]) ac = d[6:0];
        else if (d[6]) ;
        else if (d[5]) nl = d[3];
        else if (d[4]) ;
        else if (d[3]) disp = d[2];
        else if (d[2]) id = d[1];
        else if (d[1]) begin
            ac = 7'h00;
            start_busy(c, HOME);
            return;
        end else begin
            ac = 7'h00; id = 1'b1;
            for (int i = 0; i < 128; i++) mem[i] = 8'h20;
            start_busy(c, CLR);
            return;
        end
        start_busy(c, BUSY);
    endtask

    task automatic access(input logic rs, input logic rw, input logic [7:0] d, input int len, output int c);
        @(posedge clk); #1;
        LCD_E = 1'b1; LCD_RS = rs; LCD_RW = rw; LCD_data_in = d;
        if (rw) bus_q.push_back(rs ? mem[ac] : {cyc <= busy_until, ac});
        repeat (len) @(posedge clk);
        #1;
        LCD_E = 1'b0; LCD_RS = 1'($urandom); LCD_RW = 1'($urandom); LCD_data_in = 8'($urandom);
        c = cyc;
        model_commit(rs, rw, d, c);
    endtask

    task automatic wait_idle();
        while (cyc <= busy_until) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic access_idle(input logic rs, input logic rw, input logic [7:0] d, output int c);
        wait_idle();
        access(rs, rw, d, $urandom_range(1, 3), c);
    endtask

    task automatic access_at(input logic rs, input logic rw, input logic [7:0] d, input int cc);
        int c;
        while (cyc < cc - 2) begin
            @(posedge clk); #1;
        end
        access(rs, rw, d, 1, c);
    endtask

    task automatic dbg_chk(input int a, input logic [7:0] v);
        @(posedge clk); #1;
        dbg_addr = 7'(a);
        dbg_q.push_back(v);
        dbg_cyc_q.push_back(cyc + 1);
    endtask

    task automatic dbg_sweep();
        for (int a = 0; a < 128; a++) dbg_chk(a, mem[a]);
    endtask

    task automatic chk_state();
        @(posedge clk);
        @(negedge clk);
        chk("addr_counter", addr_counter, ac);
        chk("display_on", display_on, disp);
    endtask

    task automatic do_reset(input int len);
        @(posedge clk); #1;
        reset = 1'b1;
        busy_q.delete();
        repeat (len) @(posedge clk);
        #1 reset = 1'b0;
        model_reset(cyc);
    endtask

    always @(negedge clk) begin
        chk("data_oe", LCD_data_oe, LCD_E & LCD_RW & ~reset);
        if (!LCD_data_oe) chk("bus_idle", LCD_data_out, 0);
        else if (!prev_oe) begin
            if (bus_q.size() == 0) fail_now("bus_unexpected");
            else chk("bus_read", LCD_data_out, bus_q.pop_front());
        end
        prev_oe = LCD_data_oe;
        if (viol_q.size() != 0 && viol_q[0] == cyc) begin
            chk("violation", violation, 1);
            void'(viol_q.pop_front());
        end else if (violation) fail_now("violation_unexpected");
        if (dbg_cyc_q.size() != 0 && dbg_cyc_q[0] == cyc) begin
            void'(dbg_cyc_q.pop_front());
            chk("dbg_data", dbg_data, dbg_q.pop_front());
        end
        if (reset) run = 0;
        else if (busy) run++;
        else if (run > 0) begin
            if (busy_q.size() == 0) fail_now("busy_unexpected");
            else chk("busy_len", run, busy_q.pop_front());
            run = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c, t, op;
        logic rs, rw;
        logic [7:0] d;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_oe", LCD_data_oe, 0);
        chk("rst_violation", violation, 0);
        chk("rst_dbg", dbg_data, 0);
        chk("rst_ac", addr_counter, 0);
        chk("rst_display", display_on, 0);
        @(posedge clk); #1 reset = 1'b0;
        model_reset(cyc);
        repeat (200) @(posedge clk);
        #1;
        access(1'b0, 1'b1, 8'h00, 1, c);
        dbg_sweep();
        chk_state();

        access_idle(1'b0, 1'b0, 8'h38, c);
        access_idle(1'b0, 1'b0, 8'hA7, c);
        dbg_addr = 7'h27;
        access_idle(1'b1, 1'b0, 8'h41, c);
        dbg_q.push_back(8'h41);
        dbg_cyc_q.push_back(c + 1);
        access_idle(1'b1, 1'b0, 8'h42, c);
        wait_idle();
        chk_state();
        dbg_chk(8'h27, 8'h41);
        dbg_chk(8'h40, 8'h42);

        access_idle(1'b0, 1'b0, 8'h30, c);
        access_idle(1'b0, 1'b0, 8'h0C, c);
        access_idle(1'b0, 1'b0, 8'hCF, c);
        access_idle(1'b1, 1'b0, 8'h55, c);
        wait_idle();
        chk_state();
        dbg_chk(8'h4F, 8'h55);
        access_idle(1'b0, 1'b0, 8'h04, c);
        access_idle(1'b0, 1'b0, 8'h80, c);
        access_idle(1'b1, 1'b1, 8'h00, c);
        wait_idle();
        chk_state();

        access_idle(1'b1, 1'b0, 8'h33, c);
        access_at(1'b1, 1'b0, 8'h99, c + 3);
        t = busy_until;
        access_at(1'b1, 1'b0, 8'h77, t);
        access_at(1'b1, 1'b0, 8'h78, t + 1);
        wait_idle();
        chk_state();
        dbg_chk(8'h4F, 8'h33);
        dbg_chk(8'h4E, 8'h78);
        dbg_chk(8'h4D, 8'h20);

        access_idle(1'b0, 1'b0, 8'h92, c);
        access(1'b0, 1'b1, 8'h00, 2, c);
        wait_idle();

        access_idle(1'b0, 1'b0, 8'h06, c);
        access_idle(1'b0, 1'b0, 8'h80, c);
        for (int i = 0; i < 6; i++) access_idle(1'b1, 1'b0, 8'(i), c);
        wait_idle();
        for (int i = 0; i < 6; i++) dbg_chk(i, 8'(i));
        access_idle(1'b0, 1'b0, 8'h01, c);
        wait_idle();
        chk_state();
        dbg_sweep();
        access_idle(1'b1, 1'b0, 8'hAB, c);
        wait_idle();
        chk_state();
        dbg_chk(0, 8'hAB);

        access_idle(1'b0, 1'b0, 8'h01, c);
        repeat (50) @(posedge clk);
        do_reset(2);
        wait_idle();
        access(1'b0, 1'b1, 8'h00, 1, c);
        dbg_sweep();

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) != 0) wait_idle();
            else repeat ($urandom_range(0, 45)) @(posedge clk);
            op = $urandom_range(0, 9);
            rs = 1'b0; rw = 1'b0; d = 8'($urandom);
            case (op)
                0, 9: rs = 1'b1;
                1: begin rs = 1'b1; rw = 1'b1; end
                2: rw = 1'b1;
                3: d = d | 8'h80;
                4: d = 8'h04 | (d & 8'h03);
                5: d = 8'h20 | (d & 8'h1F);
                6: d = 8'h08 | (d & 8'h07);
                7: d = 8'h02 | (d & 8'h01);
                default: d = (d[7:6] == 2'b00) ? 8'h00 : d[7] ? (8'h10 | (d & 8'h0F)) : (8'h40 | (d & 8'h3F));
            endcase
            access(rs, rw, d, $urandom_range(1, 3), c);
        end
        wait_idle();
        chk_state();
        dbg_sweep();
        access(1'b0, 1'b1, 8'h00, 1, c);

        repeat (5) @(posedge clk);
        #1;
        chk("busy_q_left", busy_q.size(), 0);
        chk("viol_q_left", viol_q.size(), 0);
        chk("bus_q_left", bus_q.size(), 0);
        chk("dbg_q_left", dbg_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_16207_responder.md
Name: lcd_16207_responder

Overview:
- Cycle-accurate responder model of the HD44780-compatible LCD panel on the 16207 character-LCD pins (E/RS/RW/8-bit data).
- Sits on the panel side of the LCD pins: decodes instructions, holds DDRAM, keeps the address counter (AC) and busy flag, and drives read data back.
- Used in the system testbench and as an on-chip stand-in when no panel is fitted.
- Drives the same four pins the Avalon LCD slave drives. In that slave, E is high exactly for the read/write strobe and RS/RW/data are stable while E is high.

Parameters:
- BUSY_CYCLES, 40, clk cycles busy=1 after any instruction or data access other than clear.
- CLEAR_CYCLES, 160, clk cycles busy=1 for clear display and after reset; must be >= 128.
- HOME_CYCLES, 80, clk cycles busy=1 for return home.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- LCD_E  in  1  enable strobe, synchronous to clk
- LCD_RS  in  1  0=instruction/status, 1=data
- LCD_RW  in  1  0=write, 1=read
- LCD_data_in  in  8  bus value from the controller
- LCD_data_out  out  8  read data
- LCD_data_oe  out  1  responder drives the bus
- busy  out  1  busy flag (BF)
- addr_counter  out  7  current AC
- display_on  out  1  D bit from display on/off control
- violation  out  1  one-cycle pulse on an access illegal while busy
- dbg_addr  in  7  DDRAM peek address
- dbg_data  out  8  DDRAM[dbg_addr], registered, 1-cycle latency

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values:
  - AC=0x00, I/D=1, S=0, D=C=B=0, DL=1, N=0, F=0.
  - LCD_data_out=0x00, LCD_data_oe=0, violation=0, dbg_data=0x00.
  - busy=1 while reset is asserted. The state machine then enters CLEAR.
- States:
  - IDLE: not busy.
  - EXEC: busy, counting down.
  - CLEAR: busy, writes 0x20 into DDRAM[0..127], one entry per cycle, then counts out the remainder of CLEAR_CYCLES.
- Reset mid-operation: abandons EXEC or CLEAR and restarts the full reset sequence.
- Commit rule:
  - Track E_q, the registered LCD_E.
  - RS, RW and data are sampled every cycle E=1.
  - An access commits on the falling edge (E_q=1, E=0) using the last sample.
  - E held high for several cycles is still one access.
- Read path (combinational while LCD_E=1 and LCD_RW=1):
  - LCD_data_oe=1.
  - RS=0: LCD_data_out={busy, AC}.
  - RS=1: LCD_data_out=DDRAM[AC].
  - Otherwise oe=0 and data_out holds 0x00.
- Write instruction (RS=0, RW=0), decoded by priority of the highest set bit:
  - 1xxxxxxx: AC=data[6:0]. No range check; unused addresses are stored.
  - 01xxxxxx: CGRAM address. Accepted but not modelled.
  - 001DNFxx: DL, N, F latched.
  - 00001DCB: D, C, B latched.
  - 000001IS: I/D, S latched. S has no display effect.
  - 0000001x: AC=0, busy for HOME_CYCLES.
  - 00000001: clear. AC=0, I/D=1, enter CLEAR.
  - 00000000: ignored; busy is not set.
  - All others: busy for BUSY_CYCLES.
- Write data (RS=1, RW=0): DDRAM[AC]=data, AC steps, busy for BUSY_CYCLES.
- Read data (RS=1, RW=1) commit: AC steps, busy for BUSY_CYCLES.
- Read status (RS=0, RW=1): legal at any time, no side effects, busy unchanged.
- AC step, I/D=1 (increment):
  - N=0: 0x4F->0x00.
  - N=1: 0x27->0x40, 0x67->0x00.
  - Any other value +1, mod 128.
- AC step, I/D=0 (decrement):
  - N=0: 0x00->0x4F.
  - N=1: 0x40->0x27, 0x00->0x67.
  - Any other value -1, mod 128.
- While busy=1:
  - Any committed write or data read is ignored. No state change, no AC step, busy counter not restarted.
  - violation pulses for exactly the commit cycle.
  - A data read during busy still drives DDRAM[AC] on the bus.
- Busy timing: busy rises the cycle after commit and stays high exactly N cycles (BUSY_CYCLES, HOME_CYCLES or CLEAR_CYCLES). A commit on the same cycle busy falls is treated as not busy.
- dbg_data: reads DDRAM[dbg_addr] through a register, with 1-cycle latency. It shows each write one cycle after commit.

Test Plan:
- Reset, idle 200 cycles:
  - busy=1 for exactly 160 cycles after reset drops.
  - Status read then returns 0x00.
  - dbg_data=0x20 for every address 0..127.
- Write instr 0x38, then instr 0xA7, then data 0x41 and data 0x42, each after busy=0:
  - DDRAM[0x27]=0x41, DDRAM[0x40]=0x42.
  - addr_counter=0x41.
  - Each write gives busy=1 for 40 cycles.
- N=0: instr 0xCF, data 0x55 -> DDRAM[0x4F]=0x55, AC=0x00. Then instr 0x04, instr 0x80, data read -> bus=0x20 while E=1, AC=0x4F.
- Data write 0x99 three cycles into a busy window:
  - violation=1 for one cycle.
  - DDRAM and AC unchanged.
  - busy falls at the original time.
- Status read during busy with AC=0x12 -> bus=0x92, oe=1 only while E=1, violation stays 0.
- Fill 0x00..0x05 with data, then instr 0x01 -> busy 160 cycles, all DDRAM=0x20, AC=0, next data write increments AC. Assert reset mid-clear -> clear restarts with full 160 cycles.
